// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, FSM states and base decode for alu_exec_seq
// Contents: alu_op_e (4-bit control codes), fsm_state_e, XLEN_DEFAULT,
//           base_decode() for the RV32I-style integer ops.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLTU  = 4'b0110,
        OP_SLL   = 4'b0111,
        OP_SRL   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_MUL   = 4'b1010,
        OP_MULHU = 4'b1011,
        OP_DIVU  = 4'b1100,
        OP_REMU  = 4'b1101,
        OP_ILL   = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Integer-op decode; M-extension override is applied by the caller.
    function automatic alu_op_e base_decode(
        input logic [1:0] aluop,
        input logic [2:0] funct3,
        input logic       funct7b5,
        input logic       opb5
    );
        alu_op_e op;
        op = OP_ADD;
        if (aluop == 2'b00) begin
            op = OP_ADD;
        end else if (aluop == 2'b01) begin
            op = OP_SUB;
        end else begin
            case (funct3)
                3'b000:  op = (opb5 && funct7b5) ? OP_SUB : OP_ADD;
                3'b001:  op = OP_SLL;
                3'b010:  op = OP_SLT;
                3'b011:  op = OP_SLTU;
                3'b100:  op = OP_XOR;
                3'b101:  op = funct7b5 ? OP_SRA : OP_SRL;
                3'b110:  op = OP_OR;
                default: op = OP_AND;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiplier / restoring divider, XLEN steps per op
// Ports: i_clk, i_rst (async, active-high), i_start (load operands), i_op (alu_op_e code),
//        i_a/i_b operands, o_done (held until next start), o_result.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);

    // hi/lo form one double-width shift register: product for multiply,
    // {remainder, quotient/dividend} for divide.
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [3:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic            done_q, done_d;

    logic            is_div;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic            div_ge;

    assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_sh  = {hi_q, lo_q[XLEN-1]};
        div_ge  = (div_sh >= {1'b0, opnd_q});

        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = done_q;

        if (i_start) begin
            hi_d   = '0;
            op_d   = i_op;
            cnt_d  = '0;
            run_d  = 1'b1;
            done_d = 1'b0;
            if ((i_op == OP_DIVU) || (i_op == OP_REMU)) begin
                lo_d   = i_a;
                opnd_d = i_b;
            end else begin
                lo_d   = i_b;
                opnd_d = i_a;
            end
        end else if (run_q) begin
            if (is_div) begin
                // Zero divisor always "fits", giving all-ones quotient and
                // the dividend as remainder without special casing.
                hi_d = div_ge ? XLEN'(div_sh - {1'b0, opnd_q}) : div_sh[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], div_ge};
            end else begin
                hi_d = mul_sum[XLEN:1];
                lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign o_done   = done_q;
    assign o_result = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? hi_q : lo_q;

endmodule

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - ALU execute stage with valid/ready handshakes and optional iterative M ops
// Option macro: ALU_EXEC_SEQ_MEXT_EN (MUL/MULHU/DIVU/REMU through mdu_iter).
// Ports: i_clk, i_rst (async, active-high); i_valid/o_ready request handshake;
//        i_aluop, i_funct3, i_funct7b5, i_funct7b0, i_opb5 decode fields; i_srca/i_srcb operands;
//        o_valid/i_ready result handshake; o_result, o_zero, o_alucrtl, o_illegal result fields.
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_aluop,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7b5,
    input  logic            i_funct7b0,
    input  logic            i_opb5,
    input  logic [XLEN-1:0] i_srca,
    input  logic [XLEN-1:0] i_srcb,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic [3:0]      o_alucrtl,
    output logic            o_illegal
);

    localparam int SHW = $clog2(XLEN);

    fsm_state_e      state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    alu_op_e         alucrtl_q, alucrtl_d;
    alu_op_e         pend_op_q, pend_op_d;

    alu_op_e         dec_op;
    logic            dec_multi;
    logic            accept;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;

    function automatic logic [XLEN-1:0] alu_single(
        input alu_op_e         op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [SHW-1:0]  sh;
        logic [XLEN-1:0] r;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $unsigned($signed(a) >>> sh);
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef ALU_EXEC_SEQ_MEXT_EN
    logic dec_ill;
    logic ill_q, ill_d;

    always_comb begin
        dec_op    = base_decode(i_aluop, i_funct3, i_funct7b5, i_opb5);
        dec_multi = 1'b0;
        dec_ill   = 1'b0;
        if (i_aluop[1] && i_opb5 && i_funct7b0) begin
            case (i_funct3)
                3'b000: begin dec_op = OP_MUL;   dec_multi = 1'b1; end
                3'b011: begin dec_op = OP_MULHU; dec_multi = 1'b1; end
                3'b101: begin dec_op = OP_DIVU;  dec_multi = 1'b1; end
                3'b111: begin dec_op = OP_REMU;  dec_multi = 1'b1; end
                default: begin dec_op = OP_ILL;  dec_ill = 1'b1; end
            endcase
        end
    end

    mdu_iter #(
        .XLEN(XLEN)
    ) u_mdu (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (accept && dec_multi),
        .i_op    (dec_op),
        .i_a     (i_srca),
        .i_b     (i_srcb),
        .o_done  (mdu_done),
        .o_result(mdu_result)
    );

    assign o_illegal = ill_q;
`else
    logic unused_funct7b0;

    assign unused_funct7b0 = i_funct7b0;

    always_comb begin
        dec_op    = base_decode(i_aluop, i_funct3, i_funct7b5, i_opb5);
        dec_multi = 1'b0;
    end

    assign mdu_done   = 1'b0;
    assign mdu_result = '0;
    assign o_illegal  = 1'b0;
`endif

    assign o_ready = !i_rst && (state_q == ST_IDLE) && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        result_d  = result_q;
        alucrtl_d = alucrtl_q;
        pend_op_d = pend_op_q;
`ifdef ALU_EXEC_SEQ_MEXT_EN
        ill_d     = ill_q;
`endif

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_multi) begin
                        state_d   = ST_BUSY;
                        cnt_d     = '0;
                        pend_op_d = dec_op;
                    end else begin
                        valid_d   = 1'b1;
                        result_d  = alu_single(dec_op, i_srca, i_srcb);
                        alucrtl_d = dec_op;
`ifdef ALU_EXEC_SEQ_MEXT_EN
                        ill_d     = dec_ill;
`endif
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(XLEN-1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Output register was drained when the op was accepted, so
                // the result loads unconditionally here.
                state_d = ST_IDLE;
                if (mdu_done) begin
                    valid_d   = 1'b1;
                    result_d  = mdu_result;
                    alucrtl_d = pend_op_q;
`ifdef ALU_EXEC_SEQ_MEXT_EN
                    ill_d     = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            alucrtl_q <= OP_ADD;
            pend_op_q <= OP_ADD;
`ifdef ALU_EXEC_SEQ_MEXT_EN
            ill_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            alucrtl_q <= alucrtl_d;
            pend_op_q <= pend_op_d;
`ifdef ALU_EXEC_SEQ_MEXT_EN
            ill_q     <= ill_d;
`endif
        end
    end

    assign o_valid   = valid_q;
    assign o_result  = result_q;
    assign o_alucrtl = alucrtl_q;
    assign o_zero    = (result_q == '0);

endmodule

// File: doc/alu_exec_seq.md
ALU_EXEC_SEQ -- requirements
Module: alu_exec_seq

Interface
- REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8..64, power of two.
- REQ-002 SHALL have port i_clk  in  1  sole clock, rising edge.
- REQ-003 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
- REQ-004 SHALL have ports i_valid in 1 and o_ready out 1: request handshake; transfer when both are high at a rising edge.
- REQ-005 SHALL have port i_aluop  in  2  00 add, 01 sub, 1x decode from funct fields.
- REQ-006 SHALL have ports i_funct3 in 3, i_funct7b5 in 1, i_funct7b0 in 1, i_opb5 in 1: instruction fields.
- REQ-007 SHALL have ports i_srca and i_srcb, each in, width XLEN: operands.
- REQ-008 SHALL have ports o_valid out 1 and i_ready in 1: result handshake.
- REQ-009 SHALL have ports o_result out XLEN, o_zero out 1, o_alucrtl out 4 (decoded op of held result), o_illegal out 1.

Function
- REQ-010 SHALL decode as follows. aluop 00 gives ADD 0000. aluop 01 gives SUB 0001. aluop 1x by funct3: 000 ADD, or SUB when opb5&funct7b5; 001 SLL 0111; 010 SLT 0101; 011 SLTU 0110; 100 XOR 0100; 101 SRL 1000, or SRA 1001 when funct7b5; 110 OR 0011; 111 AND 0010.
- REQ-011 SHALL use i_srcb[log2(XLEN)-1:0] as shift amount and ignore the upper bits.
- REQ-012 SHALL drive o_ready = (state==IDLE) && (!o_valid || i_ready).
- REQ-013 SHALL complete single-cycle ops accepted at edge N with o_valid=1 and registered o_result, o_alucrtl and o_illegal visible after edge N.
- REQ-014 SHALL hold o_result, o_alucrtl, o_illegal and o_valid stable while o_valid && !i_ready.
- REQ-015 SHALL clear o_valid on an edge with o_valid && i_ready unless a new single-cycle op is accepted on the same edge; in that case the new result SHALL load.
- REQ-016 SHALL compute o_zero combinationally as (o_result==0).
- REQ-017 SHALL use FSM states IDLE, BUSY, DONE. IDLE goes to BUSY on accepting a multi-cycle op. BUSY runs exactly XLEN cycles (counter 0..XLEN-1), then goes to DONE. DONE loads the output register, sets o_valid and returns to IDLE, with no stall because the output register is guaranteed empty.
- REQ-018 SHALL give multi-cycle latency: accept at edge 0, o_valid high after edge XLEN+1; o_ready SHALL stay 0 from edge 0 until return to IDLE.
- REQ-019 SHALL ignore operand inputs after acceptance, since operands are latched.
- REQ-020 SHALL wrap all arithmetic modulo 2^XLEN; SLT SHALL be signed and SLTU unsigned.

Reset
- REQ-021 SHALL set on i_rst: state IDLE, counter 0, o_valid 0, o_result 0, o_alucrtl 0000, o_illegal 0; o_zero therefore 1.
- REQ-022 SHALL abort an in-flight BUSY op when reset is asserted mid-operation, with no result produced after release.
- REQ-023 SHALL hold o_ready 0 while i_rst is high.

Configuration
- REQ-024 SHALL gate M-extension support with macro ALU_EXEC_SEQ_MEXT_EN.
- REQ-025 SHALL, when ALU_EXEC_SEQ_MEXT_EN is defined, treat aluop 1x with opb5&funct7b0 as M ops:
  - funct3 000 MUL 1010 (low half), 011 MULHU 1011, 101 DIVU 1100, 111 REMU 1101, all multi-cycle.
  - Other funct3 values SHALL complete in one cycle with result 0, o_illegal=1, o_alucrtl 1111.
- REQ-026 SHALL, for DIVU/REMU with divisor 0, return quotient all-ones and remainder = dividend, taking full latency.
- REQ-027 SHALL, when the macro is undefined, ignore i_funct7b0, never enter BUSY, keep o_illegal tied 0, and instantiate no iterative core.

Structure
- REQ-028 SHALL place in package alu_pkg: 4-bit alu_op_e enum with all codes above, fsm_state_e, and default XLEN constant.
- REQ-029 SHALL place the shift-add multiplier / restoring divider in sub-module mdu_iter (start, op, operands, done, result), instantiated only under ALU_EXEC_SEQ_MEXT_EN.

Verification
- REQ-030 SHALL check: aluop 10, funct3 000, opb5=1, funct7b5=1, srca 5, srcb 7 -> next cycle o_result FFFFFFFE, o_alucrtl 0001, o_zero 0.
- REQ-031 SHALL check: funct3 101, funct7b5=1, srca 80000000, srcb 0000_0021 -> o_result C0000000 (shift 1), o_alucrtl 1001.
- REQ-032 SHALL check: back-to-back ADDs with i_ready held 0 for 3 cycles -> first result stable, o_ready 0, second accepted on the edge i_ready rises.
- REQ-033 SHALL check, with MEXT_EN: MULHU FFFFFFFF x FFFFFFFF -> FFFFFFFE with o_valid at cycle 33; DIVU 100/0 -> FFFFFFFF; REMU 100/0 -> 100.
- REQ-034 SHALL check, with MEXT_EN: DIVU 100/7 started, i_rst pulsed at cycle 10 -> o_valid stays 0, state IDLE, o_ready 1 one cycle after release.
- REQ-035 SHALL check: reset release -> o_valid 0, o_result 0, o_zero 1, o_alucrtl 0000.
